// File: rtl/frame_pkg.sv
// frame_pkg: frame geometry, scanout state encodings and row type.
// Shared by the row shader and the scanout engine.
package frame_pkg;

    localparam int ROWS = 96;
    localparam int COLS = 256;
    localparam int AW   = 7;
    localparam int XW   = 8;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ADDR,
        F_CAP
    } fetch_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } stream_state_t;

    function automatic logic is_last_row(input logic [AW-1:0] y);
        return y == AW'(ROWS - 1);
    endfunction

    function automatic logic is_last_col(input logic [XW-1:0] x);
        return x == XW'(COLS - 1);
    endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// frame_scanout_if: serial pixel stream from scanout to display driver.
// Master drives the beat and its position tags; slave drives pix_ready.
interface frame_scanout_if;
    import frame_pkg::*;

    logic          pix_valid;
    logic          pix_ready;
    logic          pix_data;
    logic [XW-1:0] pix_x;
    logic [AW-1:0] pix_y;
    logic          line_end;
    logic          frame_end;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_x,
        output pix_y,
        output line_end,
        output frame_end,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  line_end,
        input  frame_end,
        output pix_ready
    );

endinterface

// File: rtl/frame_scanout_row_serializer.sv
// row_serializer: holds the row being shifted out and the column counter.
// Column advances only on an accepted beat, so a stalled beat stays put.
module row_serializer
    import frame_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  row_t          row_in,
    input  logic          valid,
    input  logic          ready,
    output logic          pix_data,
    output logic [XW-1:0] pix_x,
    output logic          line_end,
    output logic          beat
);

    row_t          row_q, row_d;
    logic [XW-1:0] x_q, x_d;

    always_comb begin
        beat  = valid & ready;
        row_d = load ? row_in : row_q;
        x_d   = x_q;
        if (clr) begin
            x_d = '0;
        end else if (beat) begin
            x_d = is_last_col(x_q) ? '0 : x_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            x_q   <= '0;
        end else begin
            row_q <= row_d;
            x_q   <= x_d;
        end
    end

    // bit 0 is the leftmost pixel of the row
    assign pix_data = row_q[x_q];
    assign pix_x    = x_q;
    assign line_end = valid & is_last_col(x_q);

endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: streams the frame buffer out one pixel per accepted beat.
// The next row is prefetched into next_buf while the current one shifts.
module frame_scanout
    import frame_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    output logic [AW-1:0]          r_addr,
    input  row_t                   r_dout,
    frame_scanout_if.master        pix
);

    fetch_state_t  f_q, f_d;
    stream_state_t s_q, s_d;

    logic [AW-1:0] fetch_row_q, fetch_row_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [AW-1:0] y_q, y_d;
    row_t          next_buf_q, next_buf_d;
    logic          next_full_q, next_full_d;

    logic          start_acc;
    logic          ld;
    logic          cap;
    logic          beat;
    logic          line_end;
    logic          pix_valid;
    logic          pix_data;
    logic [XW-1:0] pix_x;

    assign pix_valid = (s_q == S_SHIFT);

    always_comb begin
        s_d       = s_q;
        y_d       = y_q;
        ld        = 1'b0;
        start_acc = 1'b0;
        unique case (s_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    y_d       = '0;
                    s_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (next_full_q) begin
                    ld  = 1'b1;
                    s_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (beat && line_end) begin
                    if (is_last_row(y_q)) begin
                        s_d = S_IDLE;
                    end else begin
                        y_d = y_q + 1'b1;
                        // swap in the prefetched row with no bubble
                        if (next_full_q) begin
                            ld = 1'b1;
                        end else begin
                            s_d = S_LOAD;
                        end
                    end
                end
            end
            default: s_d = S_IDLE;
        endcase
    end

    always_comb begin
        f_d      = f_q;
        r_addr_d = r_addr_q;
        cap      = 1'b0;
        unique case (f_q)
            F_IDLE: begin
                if (start_acc) begin
                    f_d = F_ADDR;
                end else if (s_q != S_IDLE && !next_full_q
                             && fetch_row_q < AW'(ROWS)) begin
                    f_d = F_ADDR;
                end
            end
            F_ADDR: begin
                r_addr_d = fetch_row_q;
                f_d      = F_CAP;
            end
            F_CAP: begin
                cap = 1'b1;
                f_d = F_IDLE;
            end
            default: f_d = F_IDLE;
        endcase
    end

    always_comb begin
        next_buf_d  = cap ? r_dout : next_buf_q;
        next_full_d = next_full_q;
        if (ld) begin
            next_full_d = 1'b0;
        end
        if (cap) begin
            next_full_d = 1'b1;
        end
        fetch_row_d = fetch_row_q;
        if (start_acc) begin
            fetch_row_d = '0;
        end else if (cap) begin
            fetch_row_d = fetch_row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q         <= F_IDLE;
            s_q         <= S_IDLE;
            fetch_row_q <= '0;
            r_addr_q    <= '0;
            y_q         <= '0;
            next_buf_q  <= '0;
            next_full_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            s_q         <= s_d;
            fetch_row_q <= fetch_row_d;
            r_addr_q    <= r_addr_d;
            y_q         <= y_d;
            next_buf_q  <= next_buf_d;
            next_full_q <= next_full_d;
        end
    end

    row_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .load     (ld),
        .row_in   (next_buf_q),
        .valid    (pix_valid),
        .ready    (pix.pix_ready),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .line_end (line_end),
        .beat     (beat)
    );

    assign ready         = (s_q == S_IDLE);
    assign r_addr        = r_addr_q;
    assign pix.pix_valid = pix_valid;
    assign pix.pix_data  = pix_data;
    assign pix.pix_x     = pix_x;
    assign pix.pix_y     = y_q;
    assign pix.line_end  = line_end;
    assign pix.frame_end = line_end & is_last_row(y_q);

endmodule
